bnn_load_sequencer: RTL and testbench
=====================================

Name: bnn_load_sequencer

Overview:
- Controller placed in front of the 8-8-4 BNN datapath.
- Accepts a stream of 12 weight bytes over a valid/ready interface and replays each byte as two nibble beats (low nibble, then high) on the datapath's nibble/load-enable port.
- Once loading is finished, it schedules single inferences: it drives the 8-bit input vector, waits the datapath's register latency, and captures the result.

Parameters:
- NUM_NEURONS, 12, number of weight bytes per full load (8 layer-1 plus 4 layer-2).
- INFER_LATENCY, 2, clock cycles from the bnn_x update until bnn_y is stable.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset; one clock (clk).
- cfg_start  in  1  one-cycle request to begin a full weight load.
- wr_valid  in  1  weight byte valid.
- wr_data  in  8  weight byte; bit 0 maps to weight bit 0.
- wr_ready  out  1  sequencer accepts wr_data this cycle.
- bnn_clear  out  1  one-cycle pulse that resets the datapath's load pointer and nibble phase.
- nib_out  out  4  nibble driven to the datapath weight bus.
- nib_load_en  out  1  nibble strobe to the datapath.
- load_done  out  1  one-cycle pulse after the last nibble of byte NUM_NEURONS-1.
- infer_valid  in  1  inference request.
- infer_x  in  8  input vector.
- infer_ready  out  1  request accepted this cycle.
- bnn_x  out  8  input vector driven to the datapath.
- bnn_y  in  8  datapath result.
- result  out  8  captured result.
- result_valid  out  1  result holds a fresh capture.
- busy  out  1  high in any state other than IDLE/READY.
- chk_expected  in  8  expected XOR checksum (optional feature only).
- chk_err  out  1  checksum mismatch flag (optional feature only).

Behaviour:
- Reset: state IDLE. All of the following are 0: wr_ready, bnn_clear, nib_out, nib_load_en, load_done, infer_ready, bnn_x, result, result_valid, busy, chk_err. Byte counter = 0.
- All outputs are registered.
- States: IDLE, CLEAR, L_WAIT, L_LO, L_HI, READY, I_WAIT, I_CAP.
- IDLE: the datapath's reset-default weights are valid, so infer_ready=1. cfg_start → CLEAR.
- READY: same behaviour as IDLE.
- CLEAR: bnn_clear=1 for exactly one cycle; counter ← 0; → L_WAIT.
- L_WAIT:
  - wr_ready=1 and nib_load_en=0.
  - On wr_valid&wr_ready, latch the byte and go to L_LO.
- L_LO:
  - nib_out=byte[3:0], nib_load_en=1, wr_ready=0.
  - Always → L_HI; L_LO is never abandoned, so the datapath nibble phase cannot desync.
- L_HI:
  - nib_out=byte[7:4], nib_load_en=1, counter+1.
  - If counter+1 == NUM_NEURONS: → READY, pulse load_done, wr_ready=0.
  - Otherwise wr_ready=1. If a byte is accepted this cycle → L_LO (back-to-back, 1 byte per 2 cycles); else → L_WAIT.
- Inference handshake:
  - In IDLE/READY, infer_valid&infer_ready: bnn_x ← infer_x, result_valid ← 0, → I_WAIT.
  - I_WAIT: wait counter runs INFER_LATENCY cycles; infer_ready=0.
  - I_CAP: result ← bnn_y, result_valid=1 (held until the next accepted request), → previous rest state (IDLE or READY).
  - Accept-to-result_valid = INFER_LATENCY+2 cycles.
- Simultaneous cfg_start and infer_valid in IDLE/READY: cfg_start wins; infer_ready=0 that cycle.
- cfg_start while busy: ignored.
- infer_valid during load: ignored (infer_ready=0).
- Reset mid-load: sequencer returns to IDLE. The datapath, on the same reset, restores default weights. No partial load is reported as done.
- bnn_x holds its last value outside inference; it is not cleared by cfg_start.
- Counter is log2(NUM_NEURONS)+1 bits wide and never wraps; it is cleared only in CLEAR or on reset.

Optional Feature:
- Macro BNN_LOAD_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator is cleared in CLEAR and XORs every accepted byte.
  - In the load_done cycle, chk_err ← (acc != chk_expected); it holds until the next CLEAR or reset.
- Undefined: chk_err is tied to 0 and chk_expected is ignored; no accumulator is synthesized.

Test Plan:
- Reset, then infer 0xFF → result_valid after 4 cycles.
- Full load, back-to-back: cfg_start, then 12 bytes 0x00..0x0B with wr_valid held → bnn_clear pulse. Nibble beats are 0,0 / 1,0 / … / B,0, with nib_load_en high 24 cycles contiguous. load_done occurs exactly once, 1 cycle after the last HI beat.
- Stalled load: byte 0xA5 presented, wr_valid dropped for 3 cycles mid-stream → L_WAIT gaps with nib_load_en=0. Every byte still emits low then high (5 then A). Byte count is 12.
- Inference after load: load all 0xFF, infer 0xFF → result_valid at accept+4, result=0xFF. Then infer 0x00 → result_valid drops at accept and rises with 0x00.
- Conflicts: cfg_start and infer_valid same cycle in READY → load starts, infer_ready=0. infer_valid during L_HI → not accepted. Reset asserted at byte 5 → IDLE, load_done never pulses.
- BNN_LOAD_CHECKSUM_EN: bytes 0x01..0x0C (XOR=0x0C), chk_expected=0x0C → chk_err=0. Repeat with chk_expected=0x0D → chk_err=1 from load_done onward.

Source files
------------

// File: rtl/bnn_load_sequencer.sv
// ---------------------------------------------------------------------------------------------
// bnn_load_sequencer
//
// Front-end controller for the 8-8-4 BNN datapath. It streams NUM_NEURONS weight bytes into
// the datapath as two nibble beats per byte (low nibble first), then schedules single
// inferences: drive the input vector, wait out the datapath latency, capture the result.
//
// Optional feature macro: BNN_LOAD_CHECKSUM_EN
//   defined   : XOR checksum of the accepted bytes is compared against chk_expected when the
//               load completes; chk_err holds the outcome until the next load or reset.
//   undefined : chk_err is tied low, chk_expected is ignored.
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   cfg_start     one-cycle request to begin a full weight load
//   wr_valid      weight byte valid
//   wr_data       weight byte (bit 0 = weight bit 0)
//   wr_ready      weight byte accepted this cycle when wr_valid is high
//   bnn_clear     one-cycle pulse resetting the datapath load pointer / nibble phase
//   nib_out       nibble on the datapath weight bus
//   nib_load_en   nibble strobe to the datapath
//   load_done     one-cycle pulse after the last nibble of the last byte
//   infer_valid   inference request
//   infer_x       inference input vector
//   infer_ready   inference request accepted this cycle when infer_valid is high
//   bnn_x         input vector driven to the datapath
//   bnn_y         datapath result
//   result        captured result
//   result_valid  result holds a fresh capture
//   busy          sequencer is neither idle nor ready
//   chk_expected  expected XOR checksum of the loaded bytes
//   chk_err       checksum mismatch flag
//
// INFER_LATENCY must be at least 1.
// ---------------------------------------------------------------------------------------------
module bnn_load_sequencer #(
    parameter int unsigned NUM_NEURONS   = 12,
    parameter int unsigned INFER_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       bnn_clear,
    output logic [3:0] nib_out,
    output logic       nib_load_en,
    output logic       load_done,
    input  logic       infer_valid,
    input  logic [7:0] infer_x,
    output logic       infer_ready,
    output logic [7:0] bnn_x,
    input  logic [7:0] bnn_y,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    input  logic [7:0] chk_expected,
    output logic       chk_err
);

    localparam int unsigned CntW  = $clog2(NUM_NEURONS) + 1;
    localparam int unsigned WaitW = (INFER_LATENCY > 1) ? $clog2(INFER_LATENCY) : 1;

    localparam logic [CntW-1:0]  LastCnt  = CntW'(NUM_NEURONS - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(INFER_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLWait,
        StLLo,
        StLHi,
        StReady,
        StIWait,
        StICap
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [7:0]        byte_q, byte_d;
    logic              loaded_q, loaded_d;

    // Registered outputs; their next values are decoded from the next state so each output
    // lines up with the state it belongs to.
    logic              wr_ready_q, wr_ready_d;
    logic              bnn_clear_q, bnn_clear_d;
    logic [3:0]        nib_out_q, nib_out_d;
    logic              nib_load_en_q, nib_load_en_d;
    logic              load_done_q, load_done_d;
    logic              infer_ready_q, infer_ready_d;
    logic [7:0]        bnn_x_q, bnn_x_d;
    logic [7:0]        result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              busy_q, busy_d;

    logic              wr_accept;
    logic              infer_accept;

    // A load request in the same cycle outranks an inference request, so ready is withdrawn
    // for that cycle to keep valid&ready an exact acceptance indication.
    assign infer_ready  = infer_ready_q & ~cfg_start;
    assign wr_accept    = wr_valid & wr_ready_q;
    assign infer_accept = infer_valid & infer_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wait_d         = wait_q;
        byte_d         = byte_q;
        loaded_d       = loaded_q;
        bnn_x_d        = bnn_x_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        load_done_d    = 1'b0;

        unique case (state_q)
            StIdle, StReady: begin
                if (cfg_start) begin
                    state_d = StClear;
                end else if (infer_accept) begin
                    bnn_x_d        = infer_x;
                    result_valid_d = 1'b0;
                    wait_d         = '0;
                    state_d        = StIWait;
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = StLWait;
            end
            StLWait: begin
                if (wr_accept) begin
                    byte_d  = wr_data;
                    state_d = StLLo;
                end
            end
            // The high beat always follows the low beat so the datapath phase stays in step.
            StLLo: begin
                state_d = StLHi;
            end
            StLHi: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StReady;
                    loaded_d    = 1'b1;
                    load_done_d = 1'b1;
                end else if (wr_accept) begin
                    byte_d  = wr_data;
                    state_d = StLLo;
                end else begin
                    state_d = StLWait;
                end
            end
            StIWait: begin
                if (wait_q == WaitLast) begin
                    state_d = StICap;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StICap: begin
                result_d       = bnn_y;
                result_valid_d = 1'b1;
                state_d        = loaded_q ? StReady : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d        = !((state_d == StIdle) || (state_d == StReady));
        infer_ready_d = !busy_d;
        bnn_clear_d   = (state_d == StClear);
        nib_load_en_d = (state_d == StLLo) || (state_d == StLHi);
        // In L_HI the byte counter still holds the completed-byte count for the current byte.
        wr_ready_d    = (state_d == StLWait) || ((state_d == StLHi) && (cnt_d != LastCnt));

        if (state_d == StLLo) begin
            nib_out_d = byte_d[3:0];
        end else if (state_d == StLHi) begin
            nib_out_d = byte_d[7:4];
        end else begin
            nib_out_d = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            wait_q         <= '0;
            byte_q         <= '0;
            loaded_q       <= 1'b0;
            wr_ready_q     <= 1'b0;
            bnn_clear_q    <= 1'b0;
            nib_out_q      <= '0;
            nib_load_en_q  <= 1'b0;
            load_done_q    <= 1'b0;
            infer_ready_q  <= 1'b0;
            bnn_x_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wait_q         <= wait_d;
            byte_q         <= byte_d;
            loaded_q       <= loaded_d;
            wr_ready_q     <= wr_ready_d;
            bnn_clear_q    <= bnn_clear_d;
            nib_out_q      <= nib_out_d;
            nib_load_en_q  <= nib_load_en_d;
            load_done_q    <= load_done_d;
            infer_ready_q  <= infer_ready_d;
            bnn_x_q        <= bnn_x_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign bnn_clear    = bnn_clear_q;
    assign nib_out      = nib_out_q;
    assign nib_load_en  = nib_load_en_q;
    assign load_done    = load_done_q;
    assign bnn_x        = bnn_x_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

`ifdef BNN_LOAD_CHECKSUM_EN
    logic [7:0] acc_q, acc_d;
    logic       chk_err_q, chk_err_d;

    always_comb begin
        acc_d     = acc_q;
        chk_err_d = chk_err_q;
        if (state_q == StClear) begin
            acc_d     = '0;
            chk_err_d = 1'b0;
        end else if (wr_accept) begin
            acc_d = acc_q ^ wr_data;
        end
        // The final byte is always accepted before its L_HI cycle, so acc_q is complete here.
        if (load_done_d) begin
            chk_err_d = (acc_q != chk_expected);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_chk_expected;
    assign unused_chk_expected = ^chk_expected;
    assign chk_err             = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_load_sequencer.sv
module tb_bnn_load_sequencer;

    localparam int NUM = 12;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       bnn_clear;
    logic [3:0] nib_out;
    logic       nib_load_en;
    logic       load_done;
    logic       infer_valid;
    logic [7:0] infer_x;
    logic       infer_ready;
    logic [7:0] bnn_x;
    logic [7:0] bnn_y;
    logic [7:0] result;
    logic       result_valid;
    logic       busy;
    logic [7:0] chk_expected;
    logic       chk_err;

    always #5 clk = ~clk;

    bnn_load_sequencer #(
        .NUM_NEURONS  (NUM),
        .INFER_LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_start   (cfg_start),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .bnn_clear   (bnn_clear),
        .nib_out     (nib_out),
        .nib_load_en (nib_load_en),
        .load_done   (load_done),
        .infer_valid (infer_valid),
        .infer_x     (infer_x),
        .infer_ready (infer_ready),
        .bnn_x       (bnn_x),
        .bnn_y       (bnn_y),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .chk_expected(chk_expected),
        .chk_err     (chk_err)
    );

    // Datapath stand-in: assembles bytes from nibble beats into an XOR key and answers
    // y = x ^ key through two register stages.
    logic [7:0] dp_key;
    logic [3:0] dp_lo;
    logic       dp_phase;
    logic [7:0] dp_s1;
    always @(posedge clk) begin
        if (reset || bnn_clear) begin
            dp_key   <= 8'h00;
            dp_lo    <= 4'h0;
            dp_phase <= 1'b0;
        end else if (nib_load_en) begin
            if (!dp_phase) dp_lo <= nib_out;
            else dp_key <= dp_key ^ {nib_out, dp_lo};
            dp_phase <= ~dp_phase;
        end
        dp_s1 <= bnn_x ^ dp_key;
        bnn_y <= dp_s1;
    end

    // Mid-cycle monitor of the datapath-side strobes.
    int         cyc = 0;
    int         ld_cnt = 0;
    int         ld_cyc = 0;
    int         clr_cnt = 0;
    logic [3:0] beat_q[$];
    int         beat_cyc[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (nib_load_en) begin
            beat_q.push_back(nib_out);
            beat_cyc.push_back(cyc);
        end
        if (load_done) begin
            ld_cnt <= ld_cnt + 1;
            ld_cyc <= cyc;
        end
        if (bnn_clear) clr_cnt <= clr_cnt + 1;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] wbytes[NUM];
    logic [7:0] model_key = 8'h00;
    logic [7:0] model_x = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xor_bytes(input int n);
        logic [7:0] a = 8'h00;
        for (int i = 0; i < n; i++) a = a ^ wbytes[i];
        return a;
    endfunction

    // Loads wbytes[0..n-1]; for n < NUM returns right after the last byte is accepted.
    task automatic do_load(input int n, input bit stall, input bit hold_inf,
                           input logic [7:0] chk_exp, input string tag);
        int         b0, ld0, clr0, bad_ir, missed, last;
        bit         got;
        logic       exp_err;
        b0     = beat_q.size();
        ld0    = ld_cnt;
        clr0   = clr_cnt;
        bad_ir = 0;
        missed = 0;
        chk_expected = chk_exp;
        cfg_start    = 1'b1;
        infer_valid  = hold_inf;
        infer_x      = ~model_x;
        #1;
        if (hold_inf) chk({tag, "/ir_conflict"}, 32'(infer_ready), 0);
        tick();
        cfg_start = 1'b0;
        chk({tag, "/clear"}, 32'(bnn_clear), 1);
        for (int i = 0; i < n; i++) begin
            if (stall && i == 5) begin
                wr_valid = 1'b0;
                repeat (3) tick();
            end
            wr_valid = 1'b1;
            wr_data  = wbytes[i];
            got      = 1'b0;
            for (int w = 0; w < 50 && !got; w++) begin
                got = wr_ready;
                if (infer_ready) bad_ir++;
                tick();
            end
            if (!got) missed++;
        end
        wr_valid = 1'b0;
        chk({tag, "/bytes_taken"}, 32'(missed), 0);
        if (n < NUM) return;
        tick();
        chk({tag, "/ir_lhi"}, 32'(infer_ready), 0);
        infer_valid = 1'b0;
        for (int w = 0; w < 8 && ld_cnt == ld0; w++) tick();
        repeat (3) tick();
        chk({tag, "/load_done_once"}, 32'(ld_cnt - ld0), 1);
        chk({tag, "/clear_once"}, 32'(clr_cnt - clr0), 1);
        chk({tag, "/ir_during_load"}, 32'(bad_ir), 0);
        chk({tag, "/bnn_x_kept"}, 32'(bnn_x), 32'(model_x));
        chk({tag, "/busy_after"}, 32'(busy), 0);
        chk({tag, "/beat_count"}, 32'(beat_q.size() - b0), 32'(2 * n));
        if (beat_q.size() == b0 + 2 * n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "/beat_lo"}, 32'(beat_q[b0 + 2 * i]), 32'(wbytes[i][3:0]));
                chk({tag, "/beat_hi"}, 32'(beat_q[b0 + 2 * i + 1]), 32'(wbytes[i][7:4]));
            end
            last = b0 + 2 * n - 1;
            chk({tag, "/done_after_hi"}, 32'(ld_cyc - beat_cyc[last]), 1);
            if (stall) chk({tag, "/stall_gap"}, 32'(beat_cyc[b0 + 10] - beat_cyc[b0 + 9] > 1), 1);
            else chk({tag, "/contiguous"}, 32'(beat_cyc[last] - beat_cyc[b0]), 32'(2 * n - 1));
        end
        model_key = xor_bytes(n);
`ifdef BNN_LOAD_CHECKSUM_EN
        exp_err = (model_key != chk_exp);
`else
        exp_err = 1'b0;
`endif
        chk({tag, "/chk_err"}, 32'(chk_err), 32'(exp_err));
    endtask

    task automatic do_infer(input logic [7:0] x, input string tag);
        int n;
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            if (infer_ready) ok = 1'b1;
            else tick();
        end
        chk({tag, "/ready"}, 32'(ok), 1);
        infer_valid = 1'b1;
        infer_x     = x;
        tick();
        infer_valid = 1'b0;
        chk({tag, "/bnn_x"}, 32'(bnn_x), 32'(x));
        chk({tag, "/rv_drop"}, 32'(result_valid), 0);
        chk({tag, "/busy"}, 32'(busy), 1);
        n = 1;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "/latency"}, 32'(n), 32'(LAT + 2));
        chk({tag, "/result"}, 32'(result), 32'(x ^ model_key));
        model_x = x;
        tick();
        chk({tag, "/rv_hold"}, 32'(result_valid), 1);
        chk({tag, "/ready_after"}, 32'(infer_ready), 1);
    endtask

    initial begin
        int ld0;
        reset        = 1'b1;
        cfg_start    = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = 8'h00;
        infer_valid  = 1'b0;
        infer_x      = 8'h00;
        chk_expected = 8'h00;
        tick();
        chk("rst/wr_ready", 32'(wr_ready), 0);
        chk("rst/bnn_clear", 32'(bnn_clear), 0);
        chk("rst/nib_out", 32'(nib_out), 0);
        chk("rst/nib_load_en", 32'(nib_load_en), 0);
        chk("rst/load_done", 32'(load_done), 0);
        chk("rst/infer_ready", 32'(infer_ready), 0);
        chk("rst/bnn_x", 32'(bnn_x), 0);
        chk("rst/result", 32'(result), 0);
        chk("rst/result_valid", 32'(result_valid), 0);
        chk("rst/busy", 32'(busy), 0);
        chk("rst/chk_err", 32'(chk_err), 0);
        reset = 1'b0;
        tick();
        chk("idle/infer_ready", 32'(infer_ready), 1);

        do_infer(8'hFF, "inf_default");

        for (int i = 0; i < NUM; i++) wbytes[i] = 8'(i);
        do_load(NUM, 1'b0, 1'b0, 8'h00, "b2b");
        do_infer(8'($urandom), "inf_b2b");

        for (int i = 0; i < NUM; i++) wbytes[i] = 8'($urandom);
        wbytes[5] = 8'hA5;
        do_load(NUM, 1'b1, 1'b0, 8'h00, "stall");
        do_infer(8'($urandom), "inf_stall");

        for (int i = 0; i < NUM; i++) wbytes[i] = 8'hFF;
        do_load(NUM, 1'b0, 1'b0, 8'h00, "ones");
        do_infer(8'hFF, "inf_ff");
        do_infer(8'h00, "inf_00");

        for (int i = 0; i < NUM; i++) wbytes[i] = 8'($urandom);
        do_load(NUM, 1'b0, 1'b1, 8'h00, "conflict");
        do_infer(8'($urandom), "inf_conflict");

        // Reset while byte 5 is being replayed.
        for (int i = 0; i < NUM; i++) wbytes[i] = 8'($urandom);
        do_load(6, 1'b0, 1'b0, 8'h00, "abort");
        ld0   = ld_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort/busy", 32'(busy), 0);
        chk("abort/nib_load_en", 32'(nib_load_en), 0);
        chk("abort/wr_ready", 32'(wr_ready), 0);
        chk("abort/bnn_x", 32'(bnn_x), 0);
        model_x   = 8'h00;
        model_key = 8'h00;
        repeat (30) tick();
        chk("abort/no_load_done", 32'(ld_cnt - ld0), 0);
        do_infer(8'($urandom), "inf_abort");

        for (int i = 0; i < NUM; i++) wbytes[i] = 8'(i + 1);
        do_load(NUM, 1'b0, 1'b0, 8'h0C, "cks_ok");
        do_load(NUM, 1'b0, 1'b0, 8'h0D, "cks_bad");
        repeat (4) tick();
`ifdef BNN_LOAD_CHECKSUM_EN
        chk("cks_bad/held", 32'(chk_err), 1);
`else
        chk("cks_bad/tied", 32'(chk_err), 0);
`endif

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM; i++) wbytes[i] = 8'($urandom);
            do_load(NUM, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                    "rand");
            do_infer(8'($urandom), "inf_rand_a");
            do_infer(8'($urandom), "inf_rand_b");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
